// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ----------------------------------------------------------------------
// instr_encoder_loader: encodes mnemonic requests into MIPS words and
// streams them to the instruction-memory write port.   Rev 1.0
// ----------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_index,
  input  logic              in_last,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t      state;
  logic        last_pending;
  logic [31:0] enc_word;
  logic        illegal;
  logic        accept;
  logic        wr_done;
  logic        full;

  always_comb begin
    enc_word = 32'h0000_0000;
    illegal  = 1'b0;
    case (in_mnem)
      4'd0:    enc_word = 32'h0000_0000;
      4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd3:    enc_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, 6'b000000};
      4'd4:    enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
      4'd5:    enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'b001111, 5'b00000, in_rt, in_imm};
      4'd10:   enc_word = {6'b000011, in_index};
      default: illegal  = 1'b1;
    endcase
  end

  assign in_ready = (state == S_RUN) & (!im_we | im_ready) & !last_pending;
  assign accept   = in_valid & in_ready;
  assign wr_done  = im_we & im_ready;
  // A word still sitting in the output register counts against the session budget.
  assign full     = (count + {{ADDR_W{1'b0}}, im_we}) == DEPTH_C;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      last_pending <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= BASE_C;
      im_wdata     <= 32'h0000_0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      count        <= '0;
    end else begin
      done <= 1'b0;
      if (wr_done) begin
        im_we   <= 1'b0;
        im_addr <= im_addr + ADDR_W'(1);
        count   <= count + (ADDR_W+1)'(1);
      end
      case (state)
        S_RUN: begin
          if (accept) begin
            if (illegal || full) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              im_we        <= 1'b1;
              im_wdata     <= enc_word;
              last_pending <= in_last;
            end
          end
          if (wr_done && last_pending) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            last_pending <= 1'b0;
          end
        end
        default: begin
          // ERR may still drain a held word above; a new session discards it.
          if (start) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            err          <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= BASE_C;
            count        <= '0;
            last_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// Randomized scoreboard bench for instr_encoder_loader with a small
// arithmetic encoding model; small DEPTH and a high BASE force overflow and wrap.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 4;
  localparam int BASE   = 12;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_ready, in_last;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_index;
  logic              im_we, im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_index(in_index), .in_last(in_last), .im_we(im_we),
    .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   m_run  = 1'b0;
  bit   exp_err = 1'b0;
  bit   err_pend = 1'b0;
  int   mcount = 0;
  int   ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
  bit   done_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from opcode/funct numbers and field positions.
  function automatic logic [31:0] model_word(input int unsigned mn, rs, rt, rd, sh, imm, idx);
    case (mn)
      1:       return (rs << 21) | (rt << 16) | (rd << 11) | 32;
      2:       return (rs << 21) | (rt << 16) | (rd << 11) | 34;
      3:       return (rt << 16) | (rd << 11) | (sh << 6);
      4:       return (rs << 21) | 8;
      5:       return (13 << 26) | (rs << 21) | (rt << 16) | imm;
      6:       return (35 << 26) | (rs << 21) | (rt << 16) | imm;
      7:       return (43 << 26) | (rs << 21) | (rt << 16) | imm;
      8:       return (4 << 26)  | (rs << 21) | (rt << 16) | imm;
      9:       return (15 << 26) | (rt << 16) | imm;
      10:      return (3 << 26)  | idx;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       im_ready = ($urandom_range(0, 3) != 0);
        1:       im_ready = 1'b1;
        default: im_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented write must match the queue head, held or not.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (mon_en) begin
        chk("done", 32'(done), 32'(done_exp));
        done_exp = 1'b0;
        chk("err", 32'(err), 32'(exp_err));
        if (im_we) begin
          if (q.size() == 0) begin
            chk("spurious_write", 32'(im_we), 32'h0);
          end else begin
            chk("im_addr", 32'(im_addr), 32'(q[0].addr));
            chk("im_wdata", im_wdata, q[0].data);
            if (im_ready) begin
              done_exp = q[0].last;
              void'(q.pop_front());
            end
          end
        end
      end
    end
  end

  int unsigned f_mn, f_rs, f_rt, f_rd, f_sh, f_imm, f_idx;
  bit f_last;

  task automatic present(input int unsigned mn, rs, rt, rd, sh, imm, idx, input bit last);
    f_mn = mn; f_rs = rs; f_rt = rt; f_rd = rd; f_sh = sh; f_imm = imm; f_idx = idx; f_last = last;
    in_valid = 1'b1;
    in_mnem  = 4'(mn);  in_rs = 5'(rs);  in_rt = 5'(rt);  in_rd = 5'(rd);
    in_shamt = 5'(sh);  in_imm = 16'(imm);  in_index = 26'(idx);  in_last = last;
  endtask

  task automatic send(input int unsigned mn, rs, rt, rd, sh, imm, idx, input bit last);
    bit acc;
    exp_t e;
    present(mn, rs, rt, rd, sh, imm, idx, last);
    acc = 1'b0;
    for (int cyc = 0; cyc < 100 && !acc; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        if (f_mn > 10 || mcount == DEPTH) begin
          err_pend = 1'b1;
          m_run = 1'b0;
        end else begin
          e.addr = ADDR_W'((BASE + mcount) % (1 << ADDR_W));
          e.data = model_word(f_mn, f_rs, f_rt, f_rd, f_sh, f_imm, f_idx);
          e.last = f_last;
          q.push_back(e);
          mcount++;
          if (f_last) m_run = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (err_pend) begin
        exp_err = 1'b1;
        err_pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'(acc), 32'h1);
      m_run = 1'b0;
    end
  endtask

  task automatic start_sess();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_run = 1'b1;
    mcount = 0;
    exp_err = 1'b0;
    chk("busy_after_start", 32'(busy), 32'h1);
    chk("addr_after_start", 32'(im_addr), 32'(BASE));
    chk("count_after_start", 32'(count), 32'h0);
  endtask

  task automatic end_sess();
    int cyc;
    cyc = 0;
    while ((q.size() != 0 || im_we) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) chk("drain_timeout", 32'(q.size()), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    chk("count_end", 32'(count), 32'(mcount));
    chk("busy_end", 32'(busy), 32'h0);
    chk("in_ready_end", 32'(in_ready), 32'h0);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_im_we", 32'(im_we), 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'(BASE));
    chk("rst_im_wdata", im_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
  endtask

  initial begin
    int len;
    int unsigned mn;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_index = '0; im_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals();
    mon_en = 1'b1;

    // Single ADD with last.
    start_sess();
    send(1, 1, 2, 3, 0, 0, 0, 1'b1);
    end_sess();

    // ORI then LUI back to back.
    start_sess();
    send(5, 0, 8, 0, 0, 16'hFFFF, 0, 1'b0);
    send(9, 7, 9, 0, 0, 16'h1234, 0, 1'b1);
    end_sess();

    // JAL stalled by memory; no request may be taken meanwhile.
    start_sess();
    ready_mode = 2;
    send(10, 0, 0, 0, 0, 0, 26'h0C00, 1'b0);
    present(3, 4, 5, 6, 7, 0, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_stall", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    ready_mode = 1;
    send(3, 4, 5, 6, 7, 0, 0, 1'b1);
    end_sess();

    // SW followed by illegal mnemonic; next session restarts cleanly.
    start_sess();
    send(7, 3, 4, 0, 0, 16'h0010, 0, 1'b0);
    send(12, 1, 1, 1, 1, 1, 1, 1'b0);
    end_sess();

    // Overflow: DEPTH+1 requests, the extra one errors.
    start_sess();
    for (int i = 0; i <= DEPTH; i++) send(6, i, i + 1, 0, 0, i * 4, 0, 1'b0);
    end_sess();

    // Randomized sessions.
    ready_mode = 0;
    for (int s = 0; s < 25; s++) begin
      start_sess();
      len = $urandom_range(1, 11);
      for (int i = 0; i < len && m_run; i++) begin
        mn = ($urandom_range(0, 29) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1),
             i == len - 1);
      end
      end_sess();
    end

    // Reset while a write is stalled.
    ready_mode = 2;
    start_sess();
    send(7, 1, 2, 0, 0, 16'h0004, 0, 1'b0);
    chk("stalled_we", 32'(im_we), 32'h1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals();
    q.delete();
    m_run = 1'b0;
    exp_err = 1'b0;
    done_exp = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;
    chk("post_reset_we", 32'(im_we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
